// File: rtl/seq_detect_param.sv
// Serial pattern detector with elaboration-time KMP transition table, Moore match flag
// and saturating match counter; overlapping or non-overlapping detection by parameter.
module seq_detect_param #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8,
  localparam int            SW      = $clog2(W+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             din,
  output logic [SW-1:0]    state,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [SW-1:0]    FULL    = SW'(W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               TBL_W   = 2 * (W + 1) * SW;

  // Longest prefix of PATTERN (capped at W) that is a suffix of
  // (first k pattern bits, then b). Evaluated only while elaborating.
  function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
    logic [W:0] s;
    logic       ok;
    int         best;
    s    = '0;
    best = 0;
    for (int j = 0; j < k; j++) s[j] = PATTERN[W-1-j];
    s[k] = b;
    for (int l = 1; l <= W; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++)
          if (s[k+1-l+i] != PATTERN[W-1-i]) ok = 1'b0;
        if (ok) best = l;
      end
    end
    return SW'(best);
  endfunction

  // Entry (2*k + b) holds the next state from state k on input bit b.
  // Without overlap, a completed match restarts as if from state 0.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    int               src;
    t = '0;
    for (int k = 0; k <= W; k++) begin
      src = (k == W && !OVERLAP) ? 0 : k;
      for (int b = 0; b < 2; b++)
        t[(2*k+b)*SW +: SW] = kmp_next(src, b == 1);
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL = build_tbl();

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  // Encodings above W match no table row and therefore fall back to 0.
  always_comb begin
    state_d = '0;
    for (int k = 0; k <= W; k++)
      if (state_q == SW'(k))
        state_d = din ? NEXT_TBL[(2*k+1)*SW +: SW] : NEXT_TBL[(2*k)*SW +: SW];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      state_q <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (state_d == FULL && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign dout      = (state_q == FULL);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default pattern with and without overlap,
// an all-zero 3-bit pattern, counter saturation, enable hold, reset and clear.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset, en, clr, din;

  logic [2:0] st_ov, st_no;
  logic       do_ov, do_no;
  logic [7:0] cnt_ov, cnt_no;

  logic [1:0] st_z, st_s;
  logic       do_z, do_s;
  logic [7:0] cnt_z;
  logic [1:0] cnt_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_detect_param dut_ov (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .state(st_ov), .dout(do_ov), .match_cnt(cnt_ov)
  );

  seq_detect_param #(.OVERLAP(1'b0)) dut_no (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .state(st_no), .dout(do_no), .match_cnt(cnt_no)
  );

  seq_detect_param #(.W(3), .PATTERN(3'b000), .OVERLAP(1'b1), .CNT_W(8)) dut_z (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .state(st_z), .dout(do_z), .match_cnt(cnt_z)
  );

  seq_detect_param #(.W(3), .PATTERN(3'b000), .OVERLAP(1'b1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .state(st_s), .dout(do_s), .match_cnt(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; clr = 1'b0; din = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One enabled edge with bit b; returns #1 after the edge for sampling.
  task automatic step(input logic b);
    @(negedge clk);
    en = 1'b1; clr = 1'b0; din = b;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] s27 = 7'b1101101;
  logic [2:0] exp_ov [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
  logic [2:0] exp_no [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd1};
  logic [1:0] exp_z  [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; din = 1'b0;
    #2;
    check("reset_state", st_ov, 0);
    check("reset_dout",  do_ov, 0);
    check("reset_cnt",   cnt_ov, 0);
    apply_reset();

    // Overlapping vs non-overlapping on 1101101, then 101 for the second
    // non-overlapping match.
    for (int i = 0; i < 7; i++) begin
      step(s27[6-i]);
      check($sformatf("ov_state_e%0d", i+1), st_ov, exp_ov[i]);
      check($sformatf("no_state_e%0d", i+1), st_no, exp_no[i]);
      check($sformatf("ov_dout_e%0d", i+1), do_ov, (i == 3 || i == 6) ? 1 : 0);
      check($sformatf("no_dout_e%0d", i+1), do_no, (i == 3) ? 1 : 0);
    end
    check("ov_cnt", cnt_ov, 2);
    check("no_cnt", cnt_no, 1);
    step(1'b1); check("no_state_e8", st_no, 2);
    step(1'b0); check("no_state_e9", st_no, 3);
    step(1'b1); check("no_state_e10", st_no, 4);
    check("no_dout_e10", do_no, 1);
    check("no_cnt_e10",  cnt_no, 2);

    // All-zero 3-bit pattern, overlapping; saturation with a 2-bit counter.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      check($sformatf("z_state_e%0d", i+1), st_z, exp_z[i]);
    end
    check("z_cnt6", cnt_z, 4);
    check("s_cnt6", cnt_s, 3);
    step(1'b0); step(1'b0);
    check("z_cnt8", cnt_z, 6);
    check("s_cnt8_sat", cnt_s, 3);
    check("z_dout8", do_z, 1);
    step(1'b1);
    check("z_break_state", st_z, 0);
    check("z_break_dout", do_z, 0);

    // Enable low holds state and counter while din toggles.
    apply_reset();
    step(1'b1); step(1'b1); step(1'b0);
    check("hold_pre", st_ov, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; din = i[0];
      @(posedge clk);
      #1;
      check($sformatf("hold_state_c%0d", i), st_ov, 3);
      check($sformatf("hold_cnt_c%0d", i), cnt_ov, 0);
    end
    step(1'b1);
    check("hold_resume_state", st_ov, 4);
    check("hold_resume_dout",  do_ov, 1);
    check("hold_resume_cnt",   cnt_ov, 1);

    // Asynchronous reset between edges, mid-match with a nonzero count.
    step(1'b1); step(1'b0);
    check("pre_rst_state", st_ov, 3);
    check("pre_rst_cnt",   cnt_ov, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_state", st_ov, 0);
    check("async_rst_dout",  do_ov, 0);
    check("async_rst_cnt",   cnt_ov, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1);
    check("post_rst_first", st_ov, 1);

    // Synchronous clear wins over an enabled matching bit.
    step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    check("pre_clr_state", st_ov, 3);
    check("pre_clr_cnt",   cnt_ov, 1);
    @(negedge clk);
    clr = 1'b1; en = 1'b1; din = 1'b1;
    @(posedge clk);
    #1;
    check("clr_state", st_ov, 0);
    check("clr_cnt",   cnt_ov, 0);
    check("clr_dout",  do_ov, 0);
    step(1'b1);
    check("post_clr_first", st_ov, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
